// File: rtl/db2_3_if.sv
// db2_3_if: delta-bias stream and bias-register strobe bundle for db2_3_gen
interface db2_3_if;
    logic        init_req;
    logic        delta_valid;
    logic [15:0] delta2_3;
    logic        delta_ready;
    logic [15:0] db2_3;
    logic        select_initial;
    logic        select_update;
    logic [7:0]  batch_cnt;
    modport master (
        output init_req, delta_valid, delta2_3,
        input  delta_ready, db2_3, select_initial, select_update, batch_cnt
    );
    modport slave (
        input  init_req, delta_valid, delta2_3,
        output delta_ready, db2_3, select_initial, select_update, batch_cnt
    );
endinterface

// File: rtl/db2_3_gen.sv
// db2_3_gen: accumulates a batch of delta2_3 terms and emits the scaled, negated bias step
module db2_3_gen #(
    parameter int BATCH    = 4,
    parameter int LR_SHIFT = 3,
    parameter int ACC_W    = 20
) (
    input  logic     clk,
    input  logic     reset,
    db2_3_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, INIT, ACCUM, SCALE, UPDATE} state_t;
    localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'(32767);
    localparam logic signed [ACC_W:0] MINV = -(ACC_W+1)'(32768);
    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [7:0]               cnt_q, cnt_d;
    logic [15:0]              db_q, db_d, sat;
    logic signed [ACC_W:0]    t;
    logic                     accept, clr;
    assign bus.delta_ready    = state_q == ACCUM && !bus.init_req && !reset;
    assign bus.select_initial = state_q == INIT && !reset;
    assign bus.select_update  = state_q == UPDATE && !bus.init_req && !reset;
    assign bus.db2_3          = db_q;
    assign bus.batch_cnt      = cnt_q;
    assign accept             = bus.delta_valid && bus.delta_ready;
    // one extra bit so negating the floor-shifted sum can never wrap
    assign t   = -($signed({acc_q[ACC_W-1], acc_q}) >>> LR_SHIFT);
    assign sat = t > MAXV ? 16'h7fff : t < MINV ? 16'h8000 : t[15:0];
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = IDLE;
            INIT:    state_d = ACCUM;
            ACCUM:   state_d = (accept && cnt_q == 8'(BATCH-1)) ? SCALE : ACCUM;
            SCALE:   state_d = UPDATE;
            UPDATE:  state_d = ACCUM;
            default: state_d = IDLE;
        endcase
        if (bus.init_req && state_q != INIT) state_d = INIT;
    end
    always_comb begin
        clr   = state_d == INIT || state_q == UPDATE;
        acc_d = clr ? '0 : accept ? acc_q + {{(ACC_W-16){bus.delta2_3[15]}}, bus.delta2_3} : acc_q;
        cnt_d = clr ? '0 : accept ? cnt_q + 8'd1 : cnt_q;
        db_d  = (state_q == SCALE && state_d == UPDATE) ? sat : db_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            db_q    <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
        end
    end
endmodule

// File: tb/tb_db2_3_gen.sv
// tb_db2_3_gen: directed and randomised-gap checks of db2_3_gen at LR_SHIFT 3 and 0
module tb_db2_3_gen;
    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;
    always #5 clk = ~clk;
    db2_3_if ifa ();
    db2_3_if ifb ();
    assign ifb.init_req    = ifa.init_req;
    assign ifb.delta_valid = ifa.delta_valid;
    assign ifb.delta2_3    = ifa.delta2_3;
    db2_3_gen #(.BATCH(4), .LR_SHIFT(3), .ACC_W(20)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
    db2_3_gen #(.BATCH(4), .LR_SHIFT(0), .ACC_W(20)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    function automatic logic [15:0] model(input int sum, input int sh);
        int t;
        t = -(sum >>> sh);
        return t > 32767 ? 16'h7fff : t < -32768 ? 16'h8000 : 16'(t);
    endfunction
    task automatic tick;
        @(posedge clk);
        #2;
    endtask
    task automatic chk_ctl(input string tag, input logic rdy, input logic si, input logic su, input logic [7:0] cnt);
        chk({tag, ".rdy"}, 16'(ifa.delta_ready), 16'(rdy));
        chk({tag, ".si"}, 16'(ifa.select_initial), 16'(si));
        chk({tag, ".su"}, 16'(ifa.select_update), 16'(su));
        chk({tag, ".su_b"}, 16'(ifb.select_update), 16'(su));
        chk({tag, ".cnt"}, 16'(ifa.batch_cnt), 16'(cnt));
    endtask
    task automatic do_init(input string tag);
        ifa.init_req = 1'b1;
        tick;
        ifa.init_req = 1'b0;
        #1;
        chk_ctl({tag, ".init"}, 1'b0, 1'b1, 1'b0, 8'd0);
        tick;
        chk_ctl({tag, ".accum"}, 1'b1, 1'b0, 1'b0, 8'd0);
    endtask
    task automatic run_batch(input string tag, input logic [3:0][15:0] v, input int gap_max);
        int sum = 0;
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(gap_max, 0)) tick;
            ifa.delta_valid = 1'b1;
            ifa.delta2_3    = v[i];
            #1;
            chk({tag, ".rdy"}, 16'(ifa.delta_ready), 16'd1);
            sum += int'($signed(v[i]));
            tick;
            ifa.delta_valid = 1'b0;
            chk({tag, ".cnt"}, 16'(ifa.batch_cnt), 16'(i + 1));
        end
        tick;
        chk_ctl({tag, ".upd"}, 1'b0, 1'b0, 1'b1, 8'd4);
        chk({tag, ".db_a"}, ifa.db2_3, model(sum, 3));
        chk({tag, ".db_b"}, ifb.db2_3, model(sum, 0));
        tick;
        chk_ctl({tag, ".post"}, 1'b1, 1'b0, 1'b0, 8'd0);
        chk({tag, ".hold_a"}, ifa.db2_3, model(sum, 3));
    endtask
    initial begin
        logic [3:0][15:0] v;
        reset           = 1'b1;
        ifa.init_req    = 1'b0;
        ifa.delta_valid = 1'b1;
        ifa.delta2_3    = 16'h0400;
        tick;
        tick;
        chk_ctl("rst", 1'b0, 1'b0, 1'b0, 8'd0);
        chk("rst.db", ifa.db2_3, 16'h0000);
        reset           = 1'b0;
        ifa.delta_valid = 1'b0;
        tick;
        chk_ctl("idle", 1'b0, 1'b0, 1'b0, 8'd0);
        do_init("t1");
        chk("t1.db", ifa.db2_3, 16'h0000);
        run_batch("t2", {4{16'h0400}}, 0);
        chk("t2.db_exp", ifa.db2_3, 16'hfe00);
        chk("t2.db_b_exp", ifb.db2_3, 16'hf000);
        run_batch("t3", {4{16'hffff}}, 0);
        chk("t3.db_exp", ifa.db2_3, 16'h0001);
        run_batch("t4n", {4{16'h8000}}, 0);
        chk("t4n.db_b_exp", ifb.db2_3, 16'h7fff);
        run_batch("t4p", {4{16'h7fff}}, 0);
        chk("t4p.db_b_exp", ifb.db2_3, 16'h8000);
        for (int i = 0; i < 2; i++) begin
            ifa.delta_valid = 1'b1;
            ifa.delta2_3    = 16'h0400;
            tick;
        end
        chk("t5.cnt2", 16'(ifa.batch_cnt), 16'd2);
        ifa.init_req = 1'b1;
        #1;
        chk("t5.rdy_blk", 16'(ifa.delta_ready), 16'd0);
        tick;
        ifa.init_req    = 1'b0;
        ifa.delta_valid = 1'b0;
        chk_ctl("t5.init", 1'b0, 1'b1, 1'b0, 8'd0);
        tick;
        chk_ctl("t5.accum", 1'b1, 1'b0, 1'b0, 8'd0);
        run_batch("t5b", {4{16'h0400}}, 0);
        chk("t5b.db_exp", ifa.db2_3, 16'hfe00);
        for (int i = 0; i < 4; i++) begin
            ifa.delta_valid = 1'b1;
            ifa.delta2_3    = 16'h0800;
            tick;
        end
        ifa.delta_valid = 1'b0;
        reset           = 1'b1;
        #1;
        chk_ctl("t6.rst_scale", 1'b0, 1'b0, 1'b0, 8'd4);
        tick;
        chk_ctl("t6.rst", 1'b0, 1'b0, 1'b0, 8'd0);
        chk("t6.db", ifa.db2_3, 16'h0000);
        chk("t6.db_b", ifb.db2_3, 16'h0000);
        reset = 1'b0;
        tick;
        tick;
        chk_ctl("t6.idle", 1'b0, 1'b0, 1'b0, 8'd0);
        do_init("t6");
        for (int b = 0; b < 100; b++) begin
            for (int i = 0; i < 4; i++) v[i] = 16'($urandom);
            run_batch("rnd", v, 3);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
